// File: rtl/tx_lane_sched_pkg.sv
// Shared constants and state encoding for the two-lane TX byte scheduler.
package tx_lane_sched_pkg;

  // K28.5 comma byte sent during link sync and whenever no lane has data.
  localparam logic [7:0] COM_IDLE   = 8'hBC;
  // K28.3 comma byte, reserved for active-link signalling.
  localparam logic [7:0] COM_ACTIVE = 8'h7C;
  // Byte driven while the link is idle or held in reset.
  localparam logic [7:0] BYTE_ZERO  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/tx_lane_sched_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req and ptr.
// After each grant, ptr moves to the lane that was not granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // Favoured lane wins if it requests; otherwise the other lane may take the slot.
  always_comb begin
    gnt = 2'b00;
    if (arb_en) begin
      if (req[0] && (!ptr || !req[1])) gnt = 2'b01;
      else if (req[1])                 gnt = 2'b10;
    end
  end

  // Pointer flips away from whoever was just served; it holds on idle slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/tx_lane_sched.sv
// Two-lane TX byte scheduler. It emits a comma-sync preamble after enable,
// then interleaves lane bytes round-robin into one registered byte stream.
module tx_lane_sched
  import tx_lane_sched_pkg::*;
#(
  parameter int SYNC_LEN = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  output logic       pop_0,
  output logic       pop_1,
  output logic [7:0] data_out,
  output logic       active,
  output logic       lane_sel
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] data_nxt;
  logic       active_nxt;
  logic       sel_nxt;
  logic       arb_en;
  logic [1:0] gnt;

  // Lanes are only consumed while running with the link enabled.
  assign arb_en = (state == ST_RUN) && enable;
  assign pop_0  = gnt[0];
  assign pop_1  = gnt[1];

  rr_arb2 u_arb (
    .clk    (clk_4f),
    .rst_n  (reset),
    .arb_en (arb_en),
    .req    ({valid_1, valid_0}),
    .gnt    (gnt)
  );

  // Next-state and next-output decode. Dropping enable from any state returns to IDLE.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    data_nxt   = BYTE_ZERO;
    active_nxt = 1'b0;
    sel_nxt    = lane_sel;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_SYNC;
          cnt_nxt   = 4'd0;
        end
        ST_SYNC: begin
          data_nxt = COM_IDLE;
          if (cnt == SYNC_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (gnt[0]) begin
            data_nxt   = data_0;
            active_nxt = 1'b1;
            sel_nxt    = 1'b0;
          end else if (gnt[1]) begin
            data_nxt   = data_1;
            active_nxt = 1'b1;
            sel_nxt    = 1'b1;
          end else begin
            data_nxt = COM_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State, sync counter and output byte registers.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      data_out <= BYTE_ZERO;
      active   <= 1'b0;
      lane_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data_out <= data_nxt;
      active   <= active_nxt;
      lane_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_tx_lane_sched.sv
// Bench for tx_lane_sched. A behavioural model predicts pops and the next
// output byte. Each predicted byte is queued and compared after the edge.
module tb_tx_lane_sched;

  localparam int SYNC_LEN = 4;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic       valid_0, valid_1;
  logic [7:0] data_0, data_1;
  logic       pop_0, pop_1;
  logic [7:0] data_out;
  logic       active;
  logic       lane_sel;

  typedef struct {
    logic [7:0] d;
    logic       a;
    logic       s;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: 0 idle, 1 sync, 2 run.
  int   m_st;
  int   m_cnt;
  logic m_ptr;
  logic m_sel;
  logic last_pop0, last_pop1;

  tx_lane_sched #(.SYNC_LEN(SYNC_LEN)) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .enable   (enable),
    .valid_0  (valid_0),
    .valid_1  (valid_1),
    .data_0   (data_0),
    .data_1   (data_1),
    .pop_0    (pop_0),
    .pop_1    (pop_1),
    .data_out (data_out),
    .active   (active),
    .lane_sel (lane_sel)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_cnt = 0;
    m_ptr = 1'b0;
    m_sel = 1'b0;
    sbq.delete();
  endtask

  // One clock cycle. Drive inputs and check pops against the model. Queue the
  // predicted output, then pop and compare it one cycle later.
  task automatic cyc(input logic en, input logic v0, input logic v1,
                     input logic [7:0] d0, input logic [7:0] d1);
    int   g;
    exp_t e, o;
    enable  = en;
    valid_0 = v0;
    valid_1 = v1;
    data_0  = d0;
    data_1  = d1;
    #1;
    g = -1;
    if (m_st == 2 && en) begin
      if (m_ptr == 1'b0) g = v0 ? 0 : (v1 ? 1 : -1);
      else               g = v1 ? 1 : (v0 ? 0 : -1);
    end
    last_pop0 = pop_0;
    last_pop1 = pop_1;
    chk("pop_0", 32'(pop_0), 32'(g == 0));
    chk("pop_1", 32'(pop_1), 32'(g == 1));
    chk("both_pop", 32'(pop_0 & pop_1), 32'd0);
    e.a = 1'b0;
    e.d = 8'h00;
    if (!en) begin
      m_st  = 0;
      m_cnt = 0;
    end else if (m_st == 0) begin
      m_st  = 1;
      m_cnt = 0;
    end else if (m_st == 1) begin
      e.d = 8'hBC;
      if (m_cnt == SYNC_LEN - 1) begin
        m_st  = 2;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (g >= 0) begin
        e.d   = (g == 0) ? d0 : d1;
        e.a   = 1'b1;
        m_sel = (g == 1);
        m_ptr = (g == 0);
      end else begin
        e.d = 8'hBC;
      end
    end
    e.s = m_sel;
    sbq.push_back(e);
    @(posedge clk_4f);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sbq.pop_front();
      chk("data_out", 32'(data_out), 32'(o.d));
      chk("active", 32'(active), 32'(o.a));
      chk("lane_sel", 32'(lane_sel), 32'(o.s));
    end
  endtask

  // Assert reset mid-cycle and verify the asynchronous clear, then release after an edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_sel", 32'(lane_sel), 32'd0);
    chk("rst_pop0", 32'(pop_0), 32'd0);
    chk("rst_pop1", 32'(pop_1), 32'd0);
    @(posedge clk_4f);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int   nbc;
    int   gap, max_gap;
    bit   seen;
    logic [7:0] seq [3];

    reset   = 1'b0;
    enable  = 1'b0;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    data_0  = 8'h00;
    data_1  = 8'h00;
    repeat (2) @(posedge clk_4f);
    #1;
    do_reset();

    // Enable with no data: 00, then SYNC_LEN commas, then commas forever.
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 8'h00, 8'h00);
      if (i >= 1) chk("idle_bc", 32'(data_out), 32'hBC);
    end

    // Both lanes valid with constant bytes: strict alternation starting at lane 0.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 1, 8'hA1, 8'hB2);
      chk("alt_data", 32'(data_out), (i % 2) ? 32'hB2 : 32'hA1);
      chk("alt_sel", 32'(lane_sel), 32'(i % 2));
      chk("alt_act", 32'(active), 32'd1);
    end

    // Only lane 1 with a three-byte burst, then quiet.
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 8'h00, seq[i]);
      chk("l1_pop", 32'(last_pop1), 32'd1);
      chk("l1_data", 32'(data_out), 32'(seq[i]));
    end
    cyc(1, 0, 0, 8'h00, 8'h00);
    chk("l1_tail", 32'(data_out), 32'hBC);
    chk("l1_tail_act", 32'(active), 32'd0);

    // Drop enable part-way through SYNC, then verify a full fresh SYNC on re-enable.
    cyc(0, 0, 0, 8'h00, 8'h00);
    cyc(1, 1, 0, 8'h5A, 8'h00);
    cyc(1, 1, 0, 8'h5A, 8'h00);
    cyc(1, 1, 0, 8'h5A, 8'h00);
    chk("sync_bc2", 32'(data_out), 32'hBC);
    cyc(0, 1, 0, 8'h5A, 8'h00);
    chk("drop_zero", 32'(data_out), 32'h00);
    nbc = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc(1, 1, 0, 8'h5A, 8'h00);
      if (active) seen = 1'b1;
      else if (data_out == 8'hBC) nbc++;
    end
    chk("resync_seen", 32'(seen), 32'd1);
    chk("resync_bc", 32'(nbc), 32'(SYNC_LEN));
    chk("resync_data", 32'(data_out), 32'h5A);

    // Lane 0 toggling and lane 1 always valid: lane 1 is never starved.
    gap = 0;
    max_gap = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1'(i % 2), 1, 8'(i), 8'(8'h80 + i));
      if (last_pop1) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
    end
    chk("l1_starve", 32'(max_gap < 2), 32'd1);

    // Reset while running with lane 0 valid, then a clean restart.
    cyc(1, 1, 0, 8'h77, 8'h00);
    valid_0 = 1'b1;
    do_reset();
    nbc = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc(1, 1, 0, 8'h3C, 8'h00);
      if (active) seen = 1'b1;
      else if (data_out == 8'hBC) nbc++;
    end
    chk("rst_resync_bc", 32'(nbc), 32'(SYNC_LEN));
    chk("rst_resync_data", 32'(data_out), 32'h3C);

    // Random traffic with occasional enable drops, checked against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/tx_lane_sched.md
TX_LANE_SCHED -- requirements
Module: tx_lane_sched

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 4, meaning number of 8'hBC COM bytes emitted after enable before data flow (range 1..15).
REQ-002 SHALL have port clk_4f, input, 1, byte clock; the only clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port enable, input, 1, link enable from PHY control.
REQ-005 SHALL have ports valid_0 and valid_1, input, 1 each, lane byte available.
REQ-006 SHALL have ports data_0 and data_1, input, 8 each, lane byte.
REQ-007 SHALL have ports pop_0 and pop_1, output, 1 each, combinational consume strobe for the lane byte.
REQ-008 SHALL have port data_out, output, 8, registered byte to paralelo-serial converter.
REQ-009 SHALL have port active, output, 1, registered; 1 = data_out carries lane data, 0 = idle/COM/reset.
REQ-010 SHALL have port lane_sel, output, 1, registered source lane of data_out.

Function
REQ-011 SHALL implement FSM states IDLE, SYNC, RUN; IDLE after reset.
REQ-012 IDLE: data_out=8'h00, active=0, pops=0; enable=1 -> SYNC.
REQ-013 SYNC: data_out=8'hBC each cycle, active=0; 4-bit counter reaches SYNC_LEN -> RUN; exactly SYNC_LEN BC bytes appear.
REQ-014 RUN grant: round-robin pointer ptr; grant ptr lane if its valid=1, else other lane if valid, else none.
REQ-015 pop_g SHALL equal 1 in the same cycle as a grant, only in RUN with enable=1; never both pops high.
REQ-016 On grant g: next cycle data_out=data_g, active=1, lane_sel=g; ptr <= ~g.
REQ-017 No grant in RUN: next cycle data_out=8'hBC, active=0, lane_sel holds, ptr holds.
REQ-018 Latency from pop to data_out SHALL be exactly 1 clk_4f cycle.
REQ-019 A lane holding valid=1 continuously SHALL be granted within 2 cycles (no starvation).
REQ-020 enable=0 in SYNC or RUN: no pop that cycle; next state IDLE; next data_out=8'h00, active=0; SYNC counter cleared.
REQ-021 enable re-asserted SHALL always restart the full SYNC sequence.
REQ-022 Valid inputs in IDLE/SYNC SHALL be ignored without pops.

Reset
REQ-023 reset=0 SHALL asynchronously force state=IDLE, counter=0, ptr=0, data_out=8'h00, active=0, lane_sel=0; pops=0 while reset=0.
REQ-024 Reset release SHALL take effect on the next clk_4f rising edge; no byte lost or duplicated beyond discarding the in-flight output.

Structure
REQ-025 Shared package SHALL hold constants COM_IDLE=8'hBC, COM_ACTIVE=8'h7C, and the state encoding (2 bits).
REQ-026 Sub-module rr_arb2 (2-way round-robin arbiter: valid in, grant out, ptr register) is natural; FSM and output registers stay in tx_lane_sched.

Verification
REQ-027 Reset mid-RUN with valid_0=1: reset=0 -> data_out=00, active=0, pop_0=0 immediately; after release+enable, 4 BC bytes precede data.
REQ-028 enable=1, no valids, SYNC_LEN=4 -> data_out BC,BC,BC,BC then BC with active=0 indefinitely.
REQ-029 RUN, both valid, data_0=8'hA1, data_1=8'hB2 constant -> data_out A1,B2,A1,B2 with lane_sel 0,1,0,1, active=1.
REQ-030 RUN, only valid_1 with bytes 11,22,33 -> pop_1 three cycles; data_out 11,22,33 one cycle later; then BC, active=0.
REQ-031 enable dropped during SYNC after 2 BC bytes -> data_out=00 next cycle; re-enable yields 4 fresh BC bytes.
REQ-032 valid_0 toggling, valid_1 constant -> lane 1 granted at least every 2nd cycle; no cycle with both pops.
